// File: rtl/result_sender_pkg.sv
// Shared types and helpers for the result_sender drain stage.
// Holds the one-hot FSM encoding, the default packed word width and the pair-index sizing helper.
package result_sender_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_WAIT = 4'b0010,
        S_SEND = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int PAIR_WIDTH         = 2 * DEFAULT_DATA_WIDTH;

    // Width of the pair counter: clog2 of the pair count, never below one bit.
    function automatic int pair_idx_width(input int thread_number);
        int pairs;
        pairs = thread_number / 2;
        if (pairs <= 1) begin
            return 1;
        end
        return $clog2(pairs);
    endfunction

endpackage

// File: rtl/result_sender_if.sv
// FIFO write port between result_sender (master) and the FPGA-to-host FIFO (slave).
// Handshake: a word is accepted on every cycle fifo_wr_en is high; fifo_almost_full high means
// the master must stop issuing new writes, while one write already in flight is still guaranteed a slot.
interface result_sender_if #(
    parameter int WIDTH = result_sender_pkg::PAIR_WIDTH
);
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_din;
    logic             fifo_almost_full;

    modport master (
        output fifo_wr_en,
        output fifo_din,
        input  fifo_almost_full
    );

    modport slave (
        input  fifo_wr_en,
        input  fifo_din,
        output fifo_almost_full
    );
endinterface

// File: rtl/result_sender.sv
// Drains THREAD_NUMBER per-thread results into a 32-bit FIFO as THREAD_NUMBER/2 packed pairs,
// then pulses done for the top-level FSM.
module result_sender
    import result_sender_pkg::*;
#(
    parameter int THREAD_NUMBER = 256,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                                bus_clk,
    input  logic                                srst,
    input  logic                                start,
    input  logic [THREAD_NUMBER*DATA_WIDTH-1:0] res_data,
    input  logic [THREAD_NUMBER-1:0]            res_valid,
    result_sender_if.master                     fifo,
    output logic                                busy,
    output logic                                done,
    output state_t                              state_dbg
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int PAIRS = THREAD_NUMBER / 2;
    localparam int IDX_W = pair_idx_width(THREAD_NUMBER);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             wr_en_q;
    logic [PW-1:0]    din_q;
    logic [PW-1:0]    pair_word;

    // Pair idx is already contiguous in res_data: odd thread lands in the upper half.
    always_comb begin
        pair_word = '0;
        for (int p = 0; p < PAIRS; p++) begin
            if (idx == IDX_W'(p)) begin
                pair_word = res_data[p*PW +: PW];
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state   <= S_IDLE;
            idx     <= '0;
            wr_en_q <= 1'b0;
            din_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_WAIT;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    busy <= 1'b1;
                    if (&res_valid) begin
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    busy <= 1'b1;
                    if (!fifo.fifo_almost_full) begin
                        wr_en_q <= 1'b1;
                        din_q   <= pair_word;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // busy stays up through the done pulse and drops on the next edge.
                    done  <= 1'b1;
                    busy  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.fifo_wr_en = wr_en_q;
    assign fifo.fifo_din   = din_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_result_sender.sv
// Directed bench for result_sender with THREAD_NUMBER=8 and res[k]=16'h1000+k.
module tb_result_sender;
    import result_sender_pkg::*;

    localparam int TN = 8;
    localparam int DW = 16;
    localparam int PW = 32;

    logic            bus_clk = 1'b0;
    logic            srst;
    logic            start;
    logic [TN*DW-1:0] res_data;
    logic [TN-1:0]   res_valid;
    logic            busy;
    logic            done;
    state_t          state_dbg;

    result_sender_if #(.WIDTH(PW)) fifo_if ();

    result_sender #(
        .THREAD_NUMBER(TN),
        .DATA_WIDTH   (DW)
    ) dut (
        .bus_clk  (bus_clk),
        .srst     (srst),
        .start    (start),
        .res_data (res_data),
        .res_valid(res_valid),
        .fifo     (fifo_if),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 bus_clk = ~bus_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic step_rec();
        step();
        if (fifo_if.fifo_wr_en === 1'b1) got_q.push_back(fifo_if.fifo_din);
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic collect(input int budget);
        int start_done;
        start_done = done_cnt;
        for (int c = 0; c < budget; c++) begin
            step_rec();
            if (done_cnt != start_done) break;
        end
    endtask

    task automatic load_exp();
        exp_q.delete();
        exp_q.push_back(32'h10011000);
        exp_q.push_back(32'h10031002);
        exp_q.push_back(32'h10051004);
        exp_q.push_back(32'h10071006);
    endtask

    task automatic clear_rec();
        got_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        start = 1'b0;
        fifo_if.fifo_almost_full = 1'b0;
        res_valid = '1;
        for (int k = 0; k < TN; k++) res_data[k*DW +: DW] = 16'h1000 + 16'(k);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        srst = 1'b0;
        n_cmp++; if (fifo_if.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", fifo_if.fifo_wr_en); end
        n_cmp++; if (fifo_if.fifo_din !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h want 00000000", fifo_if.fifo_din); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (state_dbg !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %b want 0001", state_dbg); end
        step();
        n_cmp++; if (state_dbg !== S_IDLE) begin n_bad++; $display("FAIL reset_start_ignored: got %b want 0001", state_dbg); end
    endtask

    task automatic test_basic();
        load_exp();
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || state_dbg !== S_WAIT) begin n_bad++; $display("FAIL basic_wait: busy %b state %b want 1 0010", busy, state_dbg); end
        step();
        n_cmp++; if (fifo_if.fifo_wr_en !== 1'b0 || state_dbg !== S_SEND) begin n_bad++; $display("FAIL basic_send_entry: wr %b state %b want 0 0100", fifo_if.fifo_wr_en, state_dbg); end
        for (int i = 0; i < 4; i++) begin
            logic [PW-1:0] w;
            step();
            w = exp_q.pop_front();
            n_cmp++; if (fifo_if.fifo_wr_en !== 1'b1 || fifo_if.fifo_din !== w) begin n_bad++; $display("FAIL basic_word%0d: wr %b din %h want 1 %h", i, fifo_if.fifo_wr_en, fifo_if.fifo_din, w); end
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_early_done%0d: got %b want 0", i, done); end
        end
        step();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b1 || fifo_if.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL basic_done: done %b busy %b wr %b want 1 1 0", done, busy, fifo_if.fifo_wr_en); end
        n_cmp++; if (fifo_if.fifo_din !== 32'h10071006) begin n_bad++; $display("FAIL basic_din_hold: got %h want 10071006", fifo_if.fifo_din); end
        step();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_late_valid();
        load_exp();
        clear_rec();
        res_valid = 8'h7F;
        start = 1'b1;
        step_rec();
        start = 1'b0;
        for (int c = 0; c < 10; c++) step_rec();
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL late_no_early_write: got %0d writes want 0", got_q.size()); end
        n_cmp++; if (state_dbg !== S_WAIT) begin n_bad++; $display("FAIL late_wait_state: got %b want 0010", state_dbg); end
        res_valid = 8'hFF;
        step_rec();
        n_cmp++; if (fifo_if.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL late_one_after: wr %b want 0", fifo_if.fifo_wr_en); end
        step_rec();
        n_cmp++; if (fifo_if.fifo_wr_en !== 1'b1 || fifo_if.fifo_din !== 32'h10011000) begin n_bad++; $display("FAIL late_first_write: wr %b din %h want 1 10011000", fifo_if.fifo_wr_en, fifo_if.fifo_din); end
        collect(20);
        n_cmp++; if (got_q.size() != 4 || done_cnt != 1) begin n_bad++; $display("FAIL late_count: writes %0d dones %0d want 4 1", got_q.size(), done_cnt); end
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            logic [PW-1:0] w;
            w = exp_q.pop_front();
            n_cmp++; if (got_q[i] !== w) begin n_bad++; $display("FAIL late_word%0d: got %h want %h", i, got_q[i], w); end
        end
        step();
    endtask

    task automatic test_backpressure();
        load_exp();
        clear_rec();
        start = 1'b1;
        step_rec();
        start = 1'b0;
        step_rec();
        step_rec();
        step_rec();
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL bp_two_writes: got %0d want 2", got_q.size()); end
        fifo_if.fifo_almost_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step_rec();
            n_cmp++; if (fifo_if.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d: wr %b want 0", c, fifo_if.fifo_wr_en); end
        end
        n_cmp++; if (fifo_if.fifo_din !== 32'h10031002) begin n_bad++; $display("FAIL bp_din_hold: got %h want 10031002", fifo_if.fifo_din); end
        fifo_if.fifo_almost_full = 1'b0;
        step_rec();
        n_cmp++; if (fifo_if.fifo_wr_en !== 1'b1 || fifo_if.fifo_din !== 32'h10051004) begin n_bad++; $display("FAIL bp_release: wr %b din %h want 1 10051004", fifo_if.fifo_wr_en, fifo_if.fifo_din); end
        collect(20);
        n_cmp++; if (got_q.size() != 4 || done_cnt != 1) begin n_bad++; $display("FAIL bp_count: writes %0d dones %0d want 4 1", got_q.size(), done_cnt); end
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            logic [PW-1:0] w;
            w = exp_q.pop_front();
            n_cmp++; if (got_q[i] !== w) begin n_bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], w); end
        end
        step();
    endtask

    task automatic test_mid_reset();
        clear_rec();
        start = 1'b1;
        step_rec();
        start = 1'b0;
        for (int c = 0; c < 3; c++) step_rec();
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL mr_two_writes: got %0d want 2", got_q.size()); end
        srst = 1'b1;
        step_rec();
        srst = 1'b0;
        n_cmp++; if (fifo_if.fifo_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mr_after_reset: wr %b busy %b done %b want 0 0 0", fifo_if.fifo_wr_en, busy, done); end
        for (int c = 0; c < 4; c++) step_rec();
        n_cmp++; if (done_cnt != 0 || got_q.size() != 2) begin n_bad++; $display("FAIL mr_quiet: dones %0d writes %0d want 0 2", done_cnt, got_q.size()); end
        load_exp();
        clear_rec();
        start = 1'b1;
        step_rec();
        start = 1'b0;
        collect(20);
        n_cmp++; if (got_q.size() != 4 || done_cnt != 1) begin n_bad++; $display("FAIL mr_restart_count: writes %0d dones %0d want 4 1", got_q.size(), done_cnt); end
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            logic [PW-1:0] w;
            w = exp_q.pop_front();
            n_cmp++; if (got_q[i] !== w) begin n_bad++; $display("FAIL mr_word%0d: got %h want %h", i, got_q[i], w); end
        end
        step();
    endtask

    task automatic test_ignored_start();
        clear_rec();
        start = 1'b1;
        for (int c = 0; c < 7; c++) step_rec();
        start = 1'b0;
        for (int c = 0; c < 5; c++) step_rec();
        n_cmp++; if (got_q.size() != 4 || done_cnt != 1) begin n_bad++; $display("FAIL ign_count: writes %0d dones %0d want 4 1", got_q.size(), done_cnt); end
        n_cmp++; if (state_dbg !== S_IDLE || busy !== 1'b0) begin n_bad++; $display("FAIL ign_idle: state %b busy %b want 0001 0", state_dbg, busy); end
        load_exp();
        clear_rec();
        start = 1'b1;
        step_rec();
        start = 1'b0;
        collect(20);
        n_cmp++; if (got_q.size() != 4 || done_cnt != 1) begin n_bad++; $display("FAIL ign_fresh_count: writes %0d dones %0d want 4 1", got_q.size(), done_cnt); end
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            logic [PW-1:0] w;
            w = exp_q.pop_front();
            n_cmp++; if (got_q[i] !== w) begin n_bad++; $display("FAIL ign_word%0d: got %h want %h", i, got_q[i], w); end
        end
    endtask

    task automatic test_back_to_back();
        load_exp();
        clear_rec();
        start = 1'b1;
        step_rec();
        start = 1'b0;
        collect(20);
        // done cycle is now current; a start here must begin the next batch
        start = 1'b1;
        step_rec();
        start = 1'b0;
        n_cmp++; if (state_dbg !== S_WAIT) begin n_bad++; $display("FAIL b2b_restart: state %b want 0010", state_dbg); end
        collect(20);
        n_cmp++; if (got_q.size() != 8 || done_cnt != 2) begin n_bad++; $display("FAIL b2b_count: writes %0d dones %0d want 8 2", got_q.size(), done_cnt); end
        for (int i = 4; i < got_q.size() && exp_q.size() > 0; i++) begin
            logic [PW-1:0] w;
            w = exp_q.pop_front();
            n_cmp++; if (got_q[i] !== w) begin n_bad++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], w); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_late_valid();
        test_backpressure();
        test_mid_reset();
        test_ignored_start();
        test_back_to_back();
        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/result_sender.md
# result_sender

Drain stage between the kernel array and the FPGA-to-host 32-bit FIFO. After a start pulse it waits until every thread reports a valid 16-bit result. It then packs thread results in pairs into 32-bit words and writes exactly THREAD_NUMBER/2 words into the FIFO, pausing on almost-full. Finally it pulses done so the top-level FSM can return to idle.

## Interface
Parameters:
- THREAD_NUMBER, 256: thread count; must be even and ≥ 2.
- DATA_WIDTH, 16: per-thread result width; packed word width is 2*DATA_WIDTH (32).

Ports:
- bus_clk, input, 1: single clock (PCIe bus clock).
- srst, input, 1: reset, synchronous, active-high; top level drives it from quiesce or device-not-open.
- start, input, 1: one-cycle request to begin a batch; ignored unless idle.
- res_data, input, THREAD_NUMBER*DATA_WIDTH: flattened results; thread k occupies bits [k*16+15 : k*16].
- res_valid, input, THREAD_NUMBER: per-thread result valid.
- fifo_almost_full, input, 1: FIFO almost_full (at least one free slot while high).
- fifo_wr_en, output, 1: FIFO write strobe, registered.
- fifo_din, output, 32: FIFO write data, registered.
- busy, output, 1: high whenever state ≠ IDLE.
- done, output, 1: one-cycle pulse after the last word is written.

## Operation
- The FSM uses one-hot states IDLE=4'b0001, WAIT=4'b0010, SEND=4'b0100, DONE=4'b1000.
- IDLE → WAIT on start. In any other state, start is ignored.
- WAIT → SEND when &res_valid is 1; otherwise stay in WAIT.
- SEND:
  - Pair index idx runs from 0 to THREAD_NUMBER/2−1 and is $clog2(THREAD_NUMBER/2) bits wide, minimum 1.
  - Word idx is {res[2*idx+1], res[2*idx]*}, so the low half is the even thread.
- In each SEND cycle:
  - If fifo_almost_full=0: fifo_wr_en←1, fifo_din←word(idx). If idx is last, state←DONE and idx←0; otherwise idx←idx+1.
  - If fifo_almost_full=1: fifo_wr_en←0; idx and fifo_din hold.
- DONE: done is high for this single cycle, then the FSM goes to IDLE unconditionally.
- fifo_wr_en is 0 in every state except the SEND cycles described above. fifo_din holds its last value when not writing.
- res_data and res_valid must stay stable from entry to SEND until done. The block does not capture them.
- No word is ever skipped, duplicated or written past the last pair. The total is exactly THREAD_NUMBER/2 writes per batch.

## Timing
- Reset values: state=IDLE, idx=0, fifo_wr_en=0, fifo_din=0, busy=0, done=0.
- srst at any point, including mid-SEND, has the same effect next edge: return to IDLE, clear idx, fifo_wr_en=0, no done pulse.
- Latency with results already valid and no backpressure:
  - start sampled at edge 0 → WAIT.
  - Edge 1 → SEND.
  - First fifo_wr_en is high after edge 2.
  - The last write is high after edge 1+THREAD_NUMBER/2.
  - done is high in the following cycle, and busy drops one cycle after done.
- Backpressure reaction has one cycle of latency. almost_full guarantees a free slot for the write in flight, so full is never violated.
- Back-to-back batches are allowed: start in the cycle after done begins the next batch.
- start coincident with srst: srst wins.

## Structure
- A shared package holds:
  - the state localparams;
  - a pair-index-width function (clog2 with minimum 1);
  - PAIR_WIDTH = 2*DATA_WIDTH.
- No sub-module. The pair mux, counter and FSM live inline in result_sender.

## Test plan
All scenarios use THREAD_NUMBER=8 and res[k]=16'h1000+k.
- **Basic batch:** all res_valid high, start pulse, almost_full=0 → 4 writes on consecutive cycles: 32'h10011000, 32'h10031002, 32'h10051004, 32'h10071006. done one cycle after the 4th write; busy low the cycle after.
- **Late valid:** start with res_valid=8'h7F, then raise bit 7 after 10 cycles → no write before the raise; first write 2 cycles after it; same 4 words.
- **Backpressure:** hold almost_full=1 for 5 cycles right after the second write → fifo_wr_en low throughout the hold. Third word 32'h10051004 is written 1 cycle after release. Exactly 4 writes total.
- **Mid-send reset:** srst after the second write → fifo_wr_en=0 next cycle, busy=0, no done. A new start then yields all 4 words starting from 32'h10011000.
- **Ignored start:** pulse start repeatedly during SEND → exactly 4 writes and a single done; a following start runs a fresh batch.
